// File: rtl/morse_keyer.sv
// Morse keying stage: queues dit/dah strobes in a small FIFO and replays them as a
// unit-timed key waveform with a gated square-wave sidetone.
module morse_keyer #(
    parameter int unsigned UNIT_CYCLES = 1200000,
    parameter int unsigned TONE_HALF   = 6000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dit_in,
    input  logic dah_in,
    output logic key_out,
    output logic tone_out,
    output logic busy,
    output logic fifo_full,
    output logic overflow
);

    localparam int unsigned CW = $clog2(UNIT_CYCLES);
    localparam int unsigned TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [1:0]            unit_q, unit_d;
    logic [1:0]            units_q, units_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  tone_q, tone_d;
    logic                  key_q, key_d;
    logic                  ovf_q, ovf_d;
    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW:0]           cnt_q, cnt_d;

    logic push_req, push, pop, full, empty, head, unit_done;

    // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
    always_comb begin
        push_req = dit_in | dah_in;
        full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
        empty    = (cnt_q == '0);
        pop      = (state_q == IDLE) && !empty;
        push     = push_req && !full;
        head     = mem_q[rd_q];

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = dah_in;
        end
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop  ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
        ovf_d = ovf_q | (push_req & full);
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        unit_d    = unit_q;
        units_d   = units_q;
        tcnt_d    = tcnt_q;
        tone_d    = 1'b0;
        key_d     = 1'b0;
        unit_done = (cyc_q == CW'(UNIT_CYCLES - 1));

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = MARK;
                    units_d = head ? 2'd3 : 2'd1;
                    cyc_d   = '0;
                    unit_d  = '0;
                    tcnt_d  = '0;
                    tone_d  = 1'b1;
                    key_d   = 1'b1;
                end
            end
            MARK: begin
                key_d = 1'b1;
                if (tcnt_q == TW'(TONE_HALF - 1)) begin
                    tcnt_d = '0;
                    tone_d = ~tone_q;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    tone_d = tone_q;
                end
                if (unit_done) begin
                    cyc_d = '0;
                    if (unit_q == units_q - 2'd1) begin
                        state_d = SPACE;
                        unit_d  = '0;
                        key_d   = 1'b0;
                        tone_d  = 1'b0;
                    end else begin
                        unit_d = unit_q + 2'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            SPACE: begin
                if (unit_done) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    unit_d  = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            units_q <= '0;
            tcnt_q  <= '0;
            tone_q  <= 1'b0;
            key_q   <= 1'b0;
            ovf_q   <= 1'b0;
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            units_q <= units_d;
            tcnt_q  <= tcnt_d;
            tone_q  <= tone_d;
            key_q   <= key_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_out   = key_q;
    assign tone_out  = tone_q;
    assign busy      = !empty || (state_q != IDLE);
    assign fifo_full = full;
    assign overflow  = ovf_q;

endmodule
